// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
//   Ready/valid pipeline stage register with a two-entry skid buffer, a
//   synchronous flush that inserts a bubble, and a saturating stall counter.
//   Control and data payloads are kept apart so a bubble zeroes only control.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : upstream word present
//   in_ready   : stage can accept a word (straight from a flop)
//   in_ctrl    : upstream control field  [CTRL_W]
//   in_data    : upstream data field     [DATA_W]
//   out_valid  : output word present
//   out_ready  : downstream accepts the word
//   out_ctrl   : control field, zero whenever out_valid=0
//   out_data   : data field, holds last value when empty
//   flush      : synchronous kill of all held words
//   stall_cnt  : saturating count of cycles with out_valid && !out_ready
module pipe_stage_skid #(
  parameter int unsigned CTRL_W = 19,
  parameter int unsigned DATA_W = 180,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_m_valid;
  logic [CTRL_W-1:0]   r_m_ctrl;
  logic [DATA_W-1:0]   r_m_data;
  logic                r_s_valid;
  logic [CTRL_W-1:0]   r_s_ctrl;
  logic [DATA_W-1:0]   r_s_data;
  logic                r_in_ready;
  logic [CNT_W-1:0]    r_stall;

  logic                w_accept;
  logic                w_drain;
  logic                w_stalled;

  assign w_accept  = in_valid && r_in_ready;
  assign w_drain   = r_m_valid && out_ready;
  assign w_stalled = r_m_valid && !out_ready;

  assign in_ready  = r_in_ready;
  assign out_valid = r_m_valid;
  // Bubbles must never issue writes downstream.
  assign out_ctrl  = r_m_valid ? r_m_ctrl : '0;
  assign out_data  = r_m_data;
  assign stall_cnt = r_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_m_valid  <= 1'b0;
      r_m_ctrl   <= '0;
      r_m_data   <= '0;
      r_s_valid  <= 1'b0;
      r_s_ctrl   <= '0;
      r_s_data   <= '0;
      r_in_ready <= 1'b1;
      r_stall    <= '0;
    end else begin
      // Stall counting is independent of flush; saturates instead of wrapping.
      if (w_stalled && (r_stall != '1)) begin
        r_stall <= r_stall + 1'b1;
      end

      if (flush) begin
        // Data registers are deliberately left untouched.
        r_state    <= EMPTY;
        r_m_valid  <= 1'b0;
        r_s_valid  <= 1'b0;
        r_in_ready <= 1'b1;
      end else begin
        case (r_state)
          EMPTY: begin
            if (w_accept) begin
              r_m_ctrl  <= in_ctrl;
              r_m_data  <= in_data;
              r_m_valid <= 1'b1;
              r_state   <= ONE;
            end
          end
          ONE: begin
            if (w_accept && w_drain) begin
              r_m_ctrl <= in_ctrl;
              r_m_data <= in_data;
            end else if (w_accept) begin
              // Downstream blocked: park the new word in the skid entry.
              r_s_ctrl   <= in_ctrl;
              r_s_data   <= in_data;
              r_s_valid  <= 1'b1;
              r_in_ready <= 1'b0;
              r_state    <= FULL;
            end else if (w_drain) begin
              r_m_valid <= 1'b0;
              r_state   <= EMPTY;
            end
          end
          FULL: begin
            if (w_drain) begin
              r_m_ctrl   <= r_s_ctrl;
              r_m_data   <= r_s_data;
              r_s_valid  <= 1'b0;
              r_in_ready <= 1'b1;
              r_state    <= ONE;
            end
          end
          default: begin
            r_state    <= EMPTY;
            r_m_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  localparam int CW = 19;
  localparam int DW = 180;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic          flush;
  logic [15:0]   stall_cnt;

  // Second instance with a narrow counter to observe saturation.
  logic          s_in_ready;
  logic          s_out_valid;
  logic [CW-1:0] s_out_ctrl;
  logic [DW-1:0] s_out_data;
  logic [2:0]    s_stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(3)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .flush(flush), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mkdata(input logic [31:0] s);
    logic [191:0] t;
    t = {6{s}};
    return t[DW-1:0];
  endfunction

  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } word_t;

  word_t q[$];

  logic [DW-1:0] da, db, dd, de;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    out_ready = 1'b0; flush = 1'b0;
    da = mkdata(32'hA0A0_000A);
    db = mkdata(32'hB0B0_000B);
    dd = mkdata(32'hD0D0_000D);
    de = mkdata(32'hE0E0_000E);

    // ---------------- reset state ----------------
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", 192'(out_valid), 192'(1'b0));
    check("rst_in_ready",  192'(in_ready),  192'(1'b1));
    check("rst_out_ctrl",  192'(out_ctrl),  192'(0));
    check("rst_out_data",  192'(out_data),  192'(0));
    check("rst_stall",     192'(stall_cnt), 192'(0));
    tick();
    rst = 1'b0;

    // ---------------- streaming ----------------
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_ctrl = 19'h1; in_data = mkdata(32'h1);
    tick();
    check("str1_ctrl",  192'(out_ctrl),  192'(19'h1));
    check("str1_valid", 192'(out_valid), 192'(1'b1));
    check("str1_rdy",   192'(in_ready),  192'(1'b1));
    in_ctrl = 19'h2; in_data = mkdata(32'h2);
    tick();
    check("str2_ctrl", 192'(out_ctrl), 192'(19'h2));
    check("str2_rdy",  192'(in_ready), 192'(1'b1));
    in_ctrl = 19'h3; in_data = mkdata(32'h3);
    tick();
    check("str3_ctrl", 192'(out_ctrl), 192'(19'h3));
    check("str3_data", 192'(out_data), 192'(mkdata(32'h3)));
    check("str3_rdy",  192'(in_ready), 192'(1'b1));
    in_valid = 1'b0;
    tick();
    check("str_end_valid", 192'(out_valid), 192'(1'b0));
    check("str_end_ctrl",  192'(out_ctrl),  192'(0));
    check("str_end_data",  192'(out_data),  192'(mkdata(32'h3)));

    // ---------------- back-pressure + stall count ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 19'h0A; in_data = da;
    tick();                       // EMPTY -> ONE, no stall yet
    check("bp_a_ctrl",  192'(out_ctrl),  192'(19'h0A));
    check("bp_a_rdy",   192'(in_ready),  192'(1'b1));
    check("bp_a_stall", 192'(stall_cnt), 192'(0));
    in_ctrl = 19'h0B; in_data = db;
    tick();                       // ONE -> FULL, stall 1
    check("bp_b_ctrl", 192'(out_ctrl), 192'(19'h0A));
    check("bp_b_rdy",  192'(in_ready), 192'(1'b0));
    in_valid = 1'b0;
    repeat (4) tick();            // stall 5
    check("stall5",       192'(stall_cnt),   192'(5));
    check("stall5_small", 192'(s_stall_cnt), 192'(5));
    check("stall_hold_ctrl", 192'(out_ctrl), 192'(19'h0A));
    out_ready = 1'b1;
    tick();                       // A drained, B moves to main
    check("bp_out_b_ctrl", 192'(out_ctrl),  192'(19'h0B));
    check("bp_out_b_data", 192'(out_data),  192'(db));
    check("bp_out_b_rdy",  192'(in_ready),  192'(1'b1));
    check("bp_stall_keep", 192'(stall_cnt), 192'(5));
    tick();
    check("bp_empty", 192'(out_valid), 192'(1'b0));

    // ---------------- flush in FULL with incoming word ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 19'h0D; in_data = dd;
    tick();                       // ONE, stall 5
    in_ctrl = 19'h0E; in_data = de;
    tick();                       // FULL, stall 6
    check("fl_full_rdy", 192'(in_ready), 192'(1'b0));
    in_ctrl = 19'h0C; in_data = mkdata(32'hC);
    flush = 1'b1;
    tick();                       // flush; stall still counts -> 7
    flush = 1'b0;
    check("fl_valid", 192'(out_valid), 192'(1'b0));
    check("fl_ctrl",  192'(out_ctrl),  192'(0));
    check("fl_data",  192'(out_data),  192'(dd));
    check("fl_rdy",   192'(in_ready),  192'(1'b1));
    check("fl_stall", 192'(stall_cnt), 192'(7));
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("fl_c_gone", 192'(out_valid), 192'(1'b0));

    // ---------------- saturation ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 19'h0F; in_data = mkdata(32'hF);
    tick();                       // ONE, stall stays 7
    in_valid = 1'b0;
    repeat (10) tick();           // 10 stalled cycles
    check("sat_big",   192'(stall_cnt),   192'(17));
    check("sat_small", 192'(s_stall_cnt), 192'(7));

    // flush + accept + drain together: ends empty
    in_valid = 1'b1; in_ctrl = 19'h11; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fad_valid", 192'(out_valid), 192'(1'b0));
    check("fad_rdy",   192'(in_ready),  192'(1'b1));

    // ---------------- async reset while FULL ----------------
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 19'h21; in_data = mkdata(32'h21);
    tick();
    in_ctrl = 19'h22; in_data = mkdata(32'h22);
    tick();
    in_valid = 1'b0;
    check("ar_full_rdy", 192'(in_ready), 192'(1'b0));
    #3 rst = 1'b1;
    #1;
    check("ar_valid", 192'(out_valid), 192'(1'b0));
    check("ar_rdy",   192'(in_ready),  192'(1'b1));
    check("ar_stall", 192'(stall_cnt), 192'(0));
    check("ar_ctrl",  192'(out_ctrl),  192'(0));
    rst = 1'b0;
    tick();

    // ---------------- random traffic vs queue model ----------------
    begin
      int unsigned seq;
      logic [15:0] exp_stall;
      logic [2:0]  exp_small;
      logic        acc;
      seq = 0;
      exp_stall = '0;
      exp_small = '0;
      q.delete();
      for (int i = 0; i < 10000; i++) begin
        check("rnd_valid", 192'(out_valid), 192'(q.size() > 0));
        check("rnd_rdy",   192'(in_ready),  192'(q.size() < 2));
        if (q.size() > 0) begin
          check("rnd_ctrl", 192'(out_ctrl), 192'(q[0].c));
          check("rnd_data", 192'(out_data), 192'(q[0].d));
        end else begin
          check("rnd_bubble_ctrl", 192'(out_ctrl), 192'(0));
        end
        check("rnd_stall",  192'(stall_cnt),   192'(exp_stall));
        check("rnd_small",  192'(s_stall_cnt), 192'(exp_small));

        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
        flush     = ($urandom_range(0, 31) == 0);
        in_ctrl   = CW'($urandom);
        in_data   = mkdata(seq);
        seq++;

        acc = in_valid && (q.size() < 2);
        if ((q.size() > 0) && !out_ready) begin
          if (exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
          if (exp_small != 3'h7)     exp_small = exp_small + 3'd1;
        end
        if (flush) begin
          q.delete();
        end else begin
          if ((q.size() > 0) && out_ready) void'(q.pop_front());
          if (acc) q.push_back('{c: in_ctrl, d: in_data});
        end
        tick();
      end
      flush = 1'b0; in_valid = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
